dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data memory between the MIPS core and one external requester (debug/DMA port). The core has priority. A starvation counter guarantees the external port a slot after MAX_WAIT conflicting cycles. It sits between mips/top and dmem. cpu_stall must gate the core's PC update and register-file write while the core is denied.

Parameters:
MAX_WAIT, 4, conflict cycles the external port may lose before it is forced to win (0 = external wins every conflict)
WCNT_W, 3, width of the wait counter; must satisfy 2^WCNT_W > MAX_WAIT

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  core requests a data-memory access this cycle (load or store)
cpu_we  input  1  core access is a store
cpu_addr  input  32  core byte address (alu_out)
cpu_wd  input  32  core store data
cpu_rd  output  32  read data to core; combinational copy of mem_rd
cpu_stall  output  1  core denied this cycle; core must hold PC and suppress rf/dmem writes
ext_valid  input  1  external request valid; held with its fields stable until accepted
ext_we  input  1  external access is a write
ext_addr  input  32  external byte address
ext_wd  input  32  external write data
ext_ready  output  1  external request accepted this cycle (valid&ready = transfer)
ext_rvalid  output  1  one-cycle pulse: ext_rd holds read data of previous accepted read
ext_rd  output  32  registered external read data
mem_we  output  1  dmem write enable
mem_addr  output  32  dmem address
mem_wd  output  32  dmem write data
mem_rd  input  32  dmem combinational read data
grant_ext  output  1  external port owns dmem this cycle (debug/status)

Behaviour:
- Grant is combinational per cycle. Dmem read is combinational and its write is synchronous, so every granted access completes in one cycle.
- ext_win = ext_valid & (~cpu_req | wait_cnt == MAX_WAIT).
- If ext_win: grant_ext=1, ext_ready=1, mem_* driven from ext_*, cpu_stall=cpu_req.
- Else if cpu_req: mem_* driven from cpu_*, cpu_stall=0, ext_ready=0.
- Else: mem_we=0, mem_addr=cpu_addr, mem_wd=cpu_wd, ext_ready=0.
- mem_we is never 1 unless a write access is granted that cycle.
- wait_cnt (WCNT_W bits) updates on the clock edge:
  - cleared when ext_valid=0 or ext_win=1;
  - incremented when ext_valid & cpu_req & ~ext_win;
  - saturates at MAX_WAIT.
- Fairness: with both ports continuously requesting, external is granted exactly once every MAX_WAIT+1 cycles and the core in the rest. With MAX_WAIT=0, external wins every conflict.
- External read response: on an edge where ext_win & ~ext_we, ext_rd <= mem_rd and ext_rvalid <= 1. Otherwise ext_rvalid <= 0 and ext_rd holds its value. An external write produces no rvalid.
- Back-to-back external reads yield back-to-back rvalid pulses, one per accepted read, in order.
- Same-address conflict: a core store and an external read in the same cycle cannot occur, because only one port is granted. A write granted in cycle N is visible to any read in cycle N+1.
- While reset=0 (asserted), all of the following are forced regardless of inputs:
  - ext_ready=0, cpu_stall=0, mem_we=0, grant_ext=0;
  - wait_cnt=0, ext_rvalid=0, ext_rd=0.
- Reset mid-operation: a pending rvalid is dropped and the counter clears. The first cycle after release behaves as a fresh conflict with wait_cnt=0.
- cpu_rd = mem_rd always; the core ignores it when stalled.

Test Plan:
1. Core only, MAX_WAIT=4: store 0x0000_00AA to 0x40, then load 0x40 -> mem_we=1 in the store cycle, cpu_rd=0xAA in the load cycle, cpu_stall=0 throughout, ext_ready=0.
2. External only: write 0x1234_5678 to 0x80, then read 0x80 -> ext_ready=1 both cycles; ext_rvalid pulses only the cycle after the read, with ext_rd=0x1234_5678.
3. Continuous conflict, MAX_WAIT=4, 20 cycles -> grant_ext=1 on cycles 5, 10, 15, 20; cpu_stall=1 exactly on those cycles; wait_cnt sequence 0,1,2,3,4,0.
4. MAX_WAIT=0, continuous conflict -> ext_ready=1 and cpu_stall=1 every cycle; mem_we follows ext_we.
5. Core stores 0xDEAD_BEEF to 0x10 in cycle N while external reads 0x10 and loses; external is accepted at cycle N+k -> ext_rd=0xDEAD_BEEF with ext_rvalid at N+k+1.
6. Assert reset the cycle after an accepted external read, with wait_cnt=3 -> ext_rvalid=0, ext_rd=0, mem_we=0, cpu_stall=0 immediately. After release, the conflict counter restarts at 0 and external is granted on the 5th conflict cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data memory between the MIPS core and one external
// requester (debug/DMA). The core normally has priority. A wait counter tracks
// how many conflicting cycles the external port has lost, and forces an
// external grant once that count reaches MAX_WAIT so the external port cannot
// starve.
//
// Grant is decided combinationally each cycle. Dmem reads are combinational
// and dmem writes are synchronous, so every granted access completes in one
// cycle. External read data is captured into a register and presented one
// cycle later with a single-cycle ext_rvalid pulse.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WCNT_W   = 3
) (
    input  logic        clock,
    input  logic        reset,       // asynchronous, active-low

    // core side
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,

    // external (debug/DMA) side
    input  logic        ext_valid,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wd,
    output logic        ext_ready,
    output logic        ext_rvalid,
    output logic [31:0] ext_rd,

    // data memory side
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,

    // status
    output logic        grant_ext
);

    // Counter value at which the external port is forced to win a conflict.
    localparam logic [WCNT_W-1:0] LP_MAX_WAIT = WCNT_W'(MAX_WAIT);
    localparam logic [WCNT_W-1:0] LP_CNT_ZERO = WCNT_W'(0);
    localparam logic [WCNT_W-1:0] LP_CNT_ONE  = WCNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_ext_rvalid;
    logic [31:0]       r_ext_rd;

    // -----------------------------------------------------------------------
    // Combinational decisions
    // -----------------------------------------------------------------------
    logic              w_wait_sat;
    logic              w_ext_win;
    logic              w_grant_ext;
    logic              w_ext_ready;
    logic              w_cpu_stall;
    logic              w_mem_we;
    logic [31:0]       w_mem_addr;
    logic [31:0]       w_mem_wd;
    logic [WCNT_W-1:0] w_wait_cnt_nxt;
    logic              w_ext_rd_cap;

    // The external port wins when the core is idle, or when it has already
    // lost MAX_WAIT conflicts in a row. With MAX_WAIT=0 the counter never
    // leaves zero, so the external port wins every conflict.
    assign w_wait_sat = (r_wait_cnt == LP_MAX_WAIT);
    assign w_ext_win  = ext_valid & (~cpu_req | w_wait_sat);

    // Capture read data on the edge that ends a granted external read.
    assign w_ext_rd_cap = w_ext_win & ~ext_we;

    // Port arbitration and dmem request mux; reset forces every grant off.
    always_comb begin
        w_grant_ext = 1'b0;
        w_ext_ready = 1'b0;
        w_cpu_stall = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = cpu_addr;
        w_mem_wd    = cpu_wd;
        if (!reset) begin
            // Held in reset: nothing is granted, nothing is written.
            w_grant_ext = 1'b0;
            w_ext_ready = 1'b0;
            w_cpu_stall = 1'b0;
            w_mem_we    = 1'b0;
        end else if (w_ext_win) begin
            // External owns dmem; a requesting core is told to hold.
            w_grant_ext = 1'b1;
            w_ext_ready = 1'b1;
            w_cpu_stall = cpu_req;
            w_mem_we    = ext_we;
            w_mem_addr  = ext_addr;
            w_mem_wd    = ext_wd;
        end else if (cpu_req) begin
            // Core owns dmem.
            w_mem_we    = cpu_we;
            w_mem_addr  = cpu_addr;
            w_mem_wd    = cpu_wd;
        end else begin
            // Idle: park the address on the core bus, never write.
            w_mem_we    = 1'b0;
        end
    end

    // Next value of the starvation counter: clear on win or idle, count lost
    // conflicts, saturate at MAX_WAIT.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (!ext_valid || w_ext_win) begin
            w_wait_cnt_nxt = LP_CNT_ZERO;
        end else if (cpu_req) begin
            if (w_wait_sat) begin
                w_wait_cnt_nxt = LP_MAX_WAIT;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt + LP_CNT_ONE;
            end
        end else begin
            // ext_valid with an idle core always wins; kept for completeness.
            w_wait_cnt_nxt = LP_CNT_ZERO;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= LP_CNT_ZERO;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // External read response: one rvalid pulse per accepted read, data held otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ext_rvalid <= 1'b0;
            r_ext_rd     <= 32'h0000_0000;
        end else if (w_ext_rd_cap) begin
            r_ext_rvalid <= 1'b1;
            r_ext_rd     <= mem_rd;
        end else begin
            r_ext_rvalid <= 1'b0;
            r_ext_rd     <= r_ext_rd;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cpu_rd     = mem_rd;      // core ignores it while stalled
    assign cpu_stall  = w_cpu_stall;
    assign ext_ready  = w_ext_ready;
    assign ext_rvalid = r_ext_rvalid;
    assign ext_rd     = r_ext_rd;
    assign mem_we     = w_mem_we;
    assign mem_addr   = w_mem_addr;
    assign mem_wd     = w_mem_wd;
    assign grant_ext  = w_grant_ext;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for dmem_arbiter: directed vectors, hand-computed
// expectations. A small dmem model (combinational read, synchronous write)
// sits behind the main instance; a second instance with MAX_WAIT=0 shares
// the same stimulus.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        ext_valid;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wd;
    logic        ext_ready;
    logic        ext_rvalid;
    logic [31:0] ext_rd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        grant_ext;

    // second instance, MAX_WAIT = 0
    logic [31:0] z_cpu_rd;
    logic        z_cpu_stall;
    logic        z_ext_ready;
    logic        z_ext_rvalid;
    logic [31:0] z_ext_rd;
    logic        z_mem_we;
    logic [31:0] z_mem_addr;
    logic [31:0] z_mem_wd;
    logic [31:0] z_mem_rd;
    logic        z_grant_ext;

    int n_checks;
    int n_errors;
    int win_k;

    logic [31:0] mem [0:255];

    dmem_arbiter #(.MAX_WAIT(4), .WCNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
        .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rd(ext_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .grant_ext(grant_ext)
    );

    dmem_arbiter #(.MAX_WAIT(0), .WCNT_W(1)) dut0 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(z_cpu_rd), .cpu_stall(z_cpu_stall),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
        .ext_ready(z_ext_ready), .ext_rvalid(z_ext_rvalid), .ext_rd(z_ext_rd),
        .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wd(z_mem_wd), .mem_rd(z_mem_rd),
        .grant_ext(z_grant_ext)
    );

    assign z_mem_rd = 32'h0000_0000;

    // dmem model: combinational read, write on rising edge
    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic ev, input logic ewe,
                         input logic [31:0] eaddr, input logic [31:0] ewd);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wd    = wd;
        ext_valid = ev;
        ext_we    = ewe;
        ext_addr  = eaddr;
        ext_wd    = ewd;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;

        // ---------------- reset state (with busy inputs) ----------------
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 32'h55, 1'b1, 1'b1, 32'h80, 32'h66);
        #1;
        check("rst_ext_ready", 32'(ext_ready), 32'h0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_grant_ext", 32'(grant_ext), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
        check("rst_ext_rd", ext_rd, 32'h0);
        check("rst_wait_cnt", 32'(dut.r_wait_cnt), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // ---------------- 1: core only ----------------
        drive(1'b1, 1'b1, 32'h40, 32'h0000_00AA, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("t1_st_mem_we", 32'(mem_we), 32'h1);
        check("t1_st_mem_addr", mem_addr, 32'h40);
        check("t1_st_stall", 32'(cpu_stall), 32'h0);
        check("t1_st_ext_ready", 32'(ext_ready), 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("t1_ld_cpu_rd", cpu_rd, 32'h0000_00AA);
        check("t1_ld_mem_we", 32'(mem_we), 32'h0);
        check("t1_ld_stall", 32'(cpu_stall), 32'h0);
        check("t1_ld_ext_ready", 32'(ext_ready), 32'h0);

        // ---------------- 2: external only ----------------
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        #1;
        check("t2_wr_ready", 32'(ext_ready), 32'h1);
        check("t2_wr_grant", 32'(grant_ext), 32'h1);
        check("t2_wr_mem_we", 32'(mem_we), 32'h1);
        check("t2_wr_mem_addr", mem_addr, 32'h80);
        check("t2_wr_stall", 32'(cpu_stall), 32'h0);
        @(posedge clock);
        #1;
        check("t2_wr_no_rvalid", 32'(ext_rvalid), 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        check("t2_rd_ready", 32'(ext_ready), 32'h1);
        check("t2_rd_mem_we", 32'(mem_we), 32'h0);
        @(posedge clock);
        #1;
        check("t2_rd_rvalid", 32'(ext_rvalid), 32'h1);
        check("t2_rd_data", ext_rd, 32'h1234_5678);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock);
        #1;
        check("t2_rvalid_drop", 32'(ext_rvalid), 32'h0);
        check("t2_rd_hold", ext_rd, 32'h1234_5678);

        // ---------------- 3: continuous conflict, MAX_WAIT=4 ----------------
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
            #1;
            check($sformatf("t3_grant_c%0d", k), 32'(grant_ext), (k % 5 == 0) ? 32'h1 : 32'h0);
            check($sformatf("t3_stall_c%0d", k), 32'(cpu_stall), (k % 5 == 0) ? 32'h1 : 32'h0);
            check($sformatf("t3_wcnt_c%0d", k), 32'(dut.r_wait_cnt), 32'((k - 1) % 5));
            @(posedge clock);
            #1;
            check($sformatf("t3_rvalid_c%0d", k), 32'(ext_rvalid), (k % 5 == 0) ? 32'h1 : 32'h0);
        end

        // ---------------- 4: MAX_WAIT=0 instance, continuous conflict ----------------
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, k[0], 32'h100, 32'h0);
            #1;
            check($sformatf("t4_ready_c%0d", k), 32'(z_ext_ready), 32'h1);
            check($sformatf("t4_stall_c%0d", k), 32'(z_cpu_stall), 32'h1);
            check($sformatf("t4_mem_we_c%0d", k), 32'(z_mem_we), 32'(k[0]));
        end

        // idle cycle clears the main counter
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- 5: core store wins, external read sees it later ----------------
        @(negedge clock);
        drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check("t5_n_grant", 32'(grant_ext), 32'h0);
        check("t5_n_mem_we", 32'(mem_we), 32'h1);
        check("t5_n_ready", 32'(ext_ready), 32'h0);
        win_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
            #1;
            if (grant_ext === 1'b1) begin
                win_k = k;
                break;
            end
        end
        check("t5_win_cycle", 32'(win_k), 32'h4);
        check("t5_win_addr", mem_addr, 32'h10);
        @(posedge clock);
        #1;
        check("t5_rvalid", 32'(ext_rvalid), 32'h1);
        check("t5_rd_data", ext_rd, 32'hDEAD_BEEF);

        // ---------------- 6a: reset right after an accepted read ----------------
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        @(posedge clock);
        #1;
        check("t6_pre_rvalid", 32'(ext_rvalid), 32'h1);
        check("t6_pre_rd", ext_rd, 32'h1234_5678);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'h44, 32'h77, 1'b1, 1'b1, 32'h48, 32'h88);
        #1;
        check("t6_rst_rvalid", 32'(ext_rvalid), 32'h0);
        check("t6_rst_rd", ext_rd, 32'h0);
        check("t6_rst_mem_we", 32'(mem_we), 32'h0);
        check("t6_rst_stall", 32'(cpu_stall), 32'h0);
        check("t6_rst_ready", 32'(ext_ready), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- 6b: reset with wait_cnt=3, then fresh conflict ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        end
        @(posedge clock);
        #1;
        check("t6_wcnt_before", 32'(dut.r_wait_cnt), 32'h3);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_wcnt_in_rst", 32'(dut.r_wait_cnt), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        win_k = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clock);
            #1;
            if (grant_ext === 1'b1) begin
                win_k = k;
                break;
            end
        end
        check("t6_post_win_cycle", 32'(win_k), 32'h5);

        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
